// File: rtl/sub_div_sequencer_if.sv
// sub_div_sequencer_if: divider request/result bus plus the shared subtractor hookup; SUB_DIV_SIGNED_EN adds Signed.
interface sub_div_sequencer_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
`ifdef SUB_DIV_SIGNED_EN
    logic             Signed;
`endif
    logic [63:0]      SubA;
    logic [63:0]      SubB;
    logic [63:0]      SubOut;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    modport master (
`ifdef SUB_DIV_SIGNED_EN
        output Signed,
`endif
        output Start, Dividend, Divisor, SubOut,
        input  SubA, SubB, Busy, Done, Quotient, Remainder
    );
    modport slave (
`ifdef SUB_DIV_SIGNED_EN
        input  Signed,
`endif
        input  Start, Dividend, Divisor, SubOut,
        output SubA, SubB, Busy, Done, Quotient, Remainder
    );
endinterface

// File: rtl/sub_div_sequencer.sv
// sub_div_sequencer: restoring divider sequencing an external 64-bit subtractor; SUB_DIV_SIGNED_EN enables signed mode.
module sub_div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic Clk,
    input logic Reset,
    sub_div_sequencer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [WIDTH-1:0] r, q, d;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0] p;
    logic diff_ok;
    logic [WIDTH-1:0] r_next, q_next, q_fin, r_fin, a_mag, b_mag;
    logic qneg, rneg;
    logic unused_sub;
    assign p          = {r, q[WIDTH-1]};
    assign bus.SubA   = (state == RUN) ? 64'(p) : '0;
    assign bus.SubB   = (state == RUN) ? 64'(d) : '0;
    // P < 2*D keeps the difference in range, so bit 63 is an exact borrow
    assign diff_ok    = ~bus.SubOut[63];
    assign unused_sub = ^bus.SubOut[62:WIDTH];
    assign r_next     = diff_ok ? bus.SubOut[WIDTH-1:0] : p[WIDTH-1:0];
    assign q_next     = {q[WIDTH-2:0], diff_ok};
`ifdef SUB_DIV_SIGNED_EN
    logic a_neg, b_neg;
    assign a_neg = bus.Signed & bus.Dividend[WIDTH-1];
    assign b_neg = bus.Signed & bus.Divisor[WIDTH-1];
    assign a_mag = a_neg ? -bus.Dividend : bus.Dividend;
    assign b_mag = b_neg ? -bus.Divisor : bus.Divisor;
    assign q_fin = qneg ? -q_next : q_next;
    assign r_fin = rneg ? -r_next : r_next;
`else
    logic a_neg, b_neg;
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
    assign a_mag = bus.Dividend;
    assign b_mag = bus.Divisor;
    assign q_fin = q_next;
    assign r_fin = r_next;
`endif
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            bus.Busy      <= 1'b0;
            bus.Done      <= 1'b0;
            bus.Quotient  <= '0;
            bus.Remainder <= '0;
            r             <= '0;
            q             <= '0;
            d             <= '0;
            count         <= '0;
            qneg          <= 1'b0;
            rneg          <= 1'b0;
        end else begin
            bus.Done <= 1'b0;
            if (state == IDLE) begin
                if (bus.Start && bus.Divisor == '0) begin
                    bus.Quotient  <= '1;
                    bus.Remainder <= bus.Dividend;
                    bus.Done      <= 1'b1;
                end else if (bus.Start) begin
                    d        <= b_mag;
                    q        <= a_mag;
                    r        <= '0;
                    count    <= '0;
                    qneg     <= a_neg ^ b_neg;
                    rneg     <= a_neg;
                    state    <= RUN;
                    bus.Busy <= 1'b1;
                end
            end else begin
                r     <= r_next;
                q     <= q_next;
                count <= count + 1'b1;
                if (count == CNT_W'(WIDTH - 1)) begin
                    bus.Quotient  <= q_fin;
                    bus.Remainder <= r_fin;
                    bus.Done      <= 1'b1;
                    bus.Busy      <= 1'b0;
                    state         <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_sub_div_sequencer.sv
// tb_sub_div_sequencer: table-driven and sequence checks of the divider with a modelled subtractor.
module tb_sub_div_sequencer;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int passed = 0;
    int total = 0;
    sub_div_sequencer_if #(.WIDTH(32)) bus ();
    sub_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    assign bus.SubOut = bus.SubA - bus.SubB;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] eq;
        logic [31:0] er;
        int          elat;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive a request, then wait (bounded) for Done; lat counts edges from the Start edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output int lat, output logic busy_seen, output logic subb_ok);
        bus.Start = 1'b1;
        bus.Dividend = a;
        bus.Divisor = b;
`ifdef SUB_DIV_SIGNED_EN
        bus.Signed = sgn;
`endif
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        lat = 1;
        busy_seen = 1'b0;
        subb_ok = 1'b1;
        while (!bus.Done && lat < 60) begin
            if (bus.Busy) busy_seen = 1'b1;
            if (bus.Busy && !sgn && bus.SubB !== 64'(b)) subb_ok = 1'b0;
            @(posedge Clk);
            #1 lat++;
        end
    endtask

    initial begin
        int lat, n, dones;
        logic bs, sb;
        bus.Start = 1'b0;
        bus.Dividend = '0;
        bus.Divisor = '0;
`ifdef SUB_DIV_SIGNED_EN
        bus.Signed = 1'b0;
`endif
        vecs.push_back('{"100/7",      32'd100,        32'd7,          1'b0, 32'd14,         32'd2,   33});
        vecs.push_back('{"5/0",        32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,   1});
        vecs.push_back('{"0/5",        32'd0,          32'd5,          1'b0, 32'd0,          32'd0,   33});
        vecs.push_back('{"7/7",        32'd7,          32'd7,          1'b0, 32'd1,          32'd0,   33});
        vecs.push_back('{"max/max",    32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,   33});
        vecs.push_back('{"12345678/1000", 32'd12345678, 32'd1000,      1'b0, 32'd12345,      32'd678, 33});
        vecs.push_back('{"msb/2",      32'h80000000,   32'd2,          1'b0, 32'h40000000,   32'd0,   33});
        vecs.push_back('{"max/msb",    32'hFFFFFFFF,   32'h80000000,   1'b0, 32'd1,          32'h7FFFFFFF, 33});
`ifdef SUB_DIV_SIGNED_EN
        vecs.push_back('{"s -7/2",     32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF, 33});
        vecs.push_back('{"s min/-1",   32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,   33});
        vecs.push_back('{"s -7/-2",    32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF, 33});
        vecs.push_back('{"s 7/-2",     32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,   33});
        vecs.push_back('{"u -7/2",     32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,   33});
        vecs.push_back('{"s 5/0",      32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB, 1});
`endif
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        chk("reset busy", 64'(bus.Busy), 64'd0);
        chk("reset done", 64'(bus.Done), 64'd0);
        chk("reset quotient", 64'(bus.Quotient), 64'd0);
        chk("reset remainder", 64'(bus.Remainder), 64'd0);
        chk("idle suba", bus.SubA, 64'd0);
        chk("idle subb", bus.SubB, 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, lat, bs, sb);
            chk({vecs[i].name, " quotient"}, 64'(bus.Quotient), 64'(vecs[i].eq));
            chk({vecs[i].name, " remainder"}, 64'(bus.Remainder), 64'(vecs[i].er));
            chk({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].elat));
            chk({vecs[i].name, " busy seen"}, 64'(bs), 64'(vecs[i].elat != 1));
            chk({vecs[i].name, " subb"}, 64'(sb), 64'd1);
            @(posedge Clk);
            #1;
            chk({vecs[i].name, " done one cycle"}, 64'(bus.Done), 64'd0);
            chk({vecs[i].name, " quotient held"}, 64'(bus.Quotient), 64'(vecs[i].eq));
        end

        run_op(32'hFFFFFFFF, 32'd1, 1'b0, lat, bs, sb);
        chk("b2b first quotient", 64'(bus.Quotient), 64'hFFFFFFFF);
        chk("b2b first remainder", 64'(bus.Remainder), 64'd0);
        run_op(32'd3, 32'd10, 1'b0, lat, bs, sb);
        chk("b2b second quotient", 64'(bus.Quotient), 64'd0);
        chk("b2b second remainder", 64'(bus.Remainder), 64'd3);
        chk("b2b second latency", 64'(lat), 64'd33);

        @(posedge Clk);
        #1 bus.Start = 1'b1;
        bus.Dividend = 32'd200;
        bus.Divisor = 32'd9;
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        repeat (5) @(posedge Clk);
        #1 bus.Start = 1'b1;
        bus.Dividend = 32'd1;
        bus.Divisor = 32'd1;
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        n = 7;
        while (!bus.Done && n < 60) begin
            @(posedge Clk);
            #1 n++;
        end
        chk("ignored start quotient", 64'(bus.Quotient), 64'd22);
        chk("ignored start remainder", 64'(bus.Remainder), 64'd2);
        chk("ignored start latency", 64'(n), 64'd33);

        @(posedge Clk);
        #1 bus.Start = 1'b1;
        bus.Dividend = 32'd1000;
        bus.Divisor = 32'd3;
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        chk("abort busy before", 64'(bus.Busy), 64'd1);
        repeat (10) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        chk("abort busy", 64'(bus.Busy), 64'd0);
        chk("abort quotient", 64'(bus.Quotient), 64'd0);
        chk("abort remainder", 64'(bus.Remainder), 64'd0);
        chk("abort suba", bus.SubA, 64'd0);
        dones = 0;
        repeat (40) begin
            @(posedge Clk);
            #1 if (bus.Done) dones++;
        end
        chk("abort no done", 64'(dones), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sub_div_sequencer.md
Name: sub_div_sequencer

Overview:
- Multi-cycle restoring-division controller that time-shares the 64-bit combinational subtractor to compute unsigned quotient/remainder (MIPS div, HI/LO).
- Does not contain a subtractor. It drives SubA/SubB to an externally instantiated 64-bit subtractor and reads SubOut back.
- Sits beside the ALU in EX. The pipeline stalls on Busy.

Parameters:
- WIDTH, 32, operand/result width; legal range 2..32 (guarantees no overflow in 64-bit subtractor).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  in  1  clock. Everything is on the rising edge.
- Reset  in  1  synchronous active-high reset.
- Start  in  1  request. Sampled only in IDLE.
- Dividend  in  WIDTH  numerator. Latched on an accepted Start.
- Divisor  in  WIDTH  denominator. Latched on an accepted Start.
- SubA  out  64  minuend to the shared subtractor.
- SubB  out  64  subtrahend to the shared subtractor.
- SubOut  in  64  SubA - SubB from the subtractor (combinational).
- Busy  out  1  high while iterating.
- Done  out  1  one-cycle pulse when results update.
- Quotient  out  WIDTH  registered result. Held until the next Done.
- Remainder  out  WIDTH  registered result. Held until the next Done.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, named Reset.
- Reset values: state=IDLE; Busy=0; Done=0; Quotient=0; Remainder=0; internal R, Q, D, count all 0.
- States: IDLE, RUN.
- IDLE:
  - SubA=0, SubB=0.
  - On an edge with Start=1 and Divisor!=0 (edge E0): D<=Divisor, Q<=Dividend, R<=0, count<=0, go to RUN, Busy<=1.
  - On an edge with Start=1 and Divisor==0: stay in IDLE. Quotient<={WIDTH{1}}, Remainder<=Dividend, Done<=1. Latency is 1 edge.
- RUN, combinational drive:
  - P = {R, Q[WIDTH-1]}, WIDTH+1 bits.
  - SubA = zero-extend(P) to 64.
  - SubB = zero-extend(D) to 64.
- RUN, each edge E1..EWIDTH:
  - If SubOut[63]==0: R<=SubOut[WIDTH-1:0] and Q<={Q[WIDTH-2:0],1'b1}.
  - Otherwise: R<=P[WIDTH-1:0] and Q<={Q[WIDTH-2:0],1'b0}.
  - count<=count+1.
- Completion at edge EWIDTH (count==WIDTH-1):
  - Quotient and Remainder take the new Q and R values.
  - Done<=1, Busy<=0, return to IDLE.
  - Done is high exactly one cycle, in the cycle after EWIDTH. That cycle is IDLE, so a Start there is accepted (back-to-back operation).
- Latency: Start edge to Done-high is WIDTH+1 edges; the result is visible after edge EWIDTH.
- Done is 0 on every edge that does not produce a result.
- Start while Busy=1 is ignored. Operand inputs are not re-sampled during RUN.
- Quotient/Remainder change only on the completion edge or the divide-by-zero edge.
- Reset asserted mid-RUN aborts the operation:
  - All reset values apply on that edge.
  - No Done for the aborted operation.
- Width rule: P < 2*D <= 2^(WIDTH+1), so the 64-bit difference never wraps. SubOut[63] is an exact borrow flag.

Optional Feature:
- Macro: SUB_DIV_SIGNED_EN.
- When defined:
  - Adds port "Signed in 1". When Signed=1 at the accepted Start, operands are two's-complement.
  - The magnitudes are latched in D/Q. The magnitude of the most-negative value fits as unsigned WIDTH.
  - Sign flags are stored: qneg = sign(Dividend) XOR sign(Divisor); rneg = sign(Dividend).
  - On the completion edge, Quotient is negated if qneg and Remainder is negated if rneg.
  - Divide-by-zero behaviour is identical to unsigned: all-ones quotient, raw Dividend as remainder.
  - Signed=0 gives bit-identical unsigned results.
- When undefined: no Signed port, unsigned-only operation, no sign logic.

Test Plan:
- Reset, then Start with Dividend=100, Divisor=7 -> Busy for 32 cycles; Done pulse after E32; Quotient=14, Remainder=2. SubB=0x0000000000000007 throughout RUN.
- Dividend=0xFFFFFFFF, Divisor=1, then Dividend=3, Divisor=10 on the Done cycle (back-to-back) -> Quotient=0xFFFFFFFF, Remainder=0; then Quotient=0, Remainder=3 exactly 33 edges after the second Start.
- Dividend=5, Divisor=0 -> Done in the cycle after E0, Busy never high; Quotient=0xFFFFFFFF, Remainder=5.
- Start 200/9; pulse Start with 1/1 at iteration 5 -> second Start ignored; result Quotient=22, Remainder=2.
- Start 1000/3; assert Reset at iteration 10 -> Busy=0, Quotient=0, Remainder=0 on the next cycle. No Done within 40 cycles. SubA=0 in IDLE.
- With SUB_DIV_SIGNED_EN, Signed=1:
  - -7/2 -> Quotient=0xFFFFFFFD, Remainder=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF -> Quotient=0x80000000, Remainder=0.
